mips16_boot_loader: RTL and testbench
=====================================

# mips16_boot_loader

Byte-stream boot loader upstream of the 16-bit single-cycle `mips` core. It receives a length-prefixed program image over a valid/ready byte interface and assembles big-endian 16-bit instruction words. Each word is written into the core's instruction memory. The `mips` reset is held asserted until the image is complete, then released so execution starts at PC 0.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width; capacity 2^ADDR_W words; legal range 1..15.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `in_valid` in 1: upstream byte valid.
- `in_data` in 8: upstream byte.
- `in_ready` out 1: loader can accept a byte.
- `imem_we` out 1: instruction-memory write strobe, one cycle per word.
- `imem_addr` out ADDR_W: word address for the write.
- `imem_wdata` out 16: instruction word.
- `cpu_reset` out 1: active-high reset driven to the `mips` core's `reset`.
- `done` out 1: image loaded; core running.
- `error` out 1: image rejected; core held in reset.
- `word_count` out ADDR_W+1: number of words written since reset.

## Operation
- A byte is accepted on a rising edge with `in_valid & in_ready`. Nothing is consumed otherwise, and `in_data` is ignored.
- Stream format:
  - LEN_HI, then LEN_LO: N, a 16-bit word count.
  - N words, each sent as a high byte then a low byte.
  - With `MIPS16_BOOT_CHECKSUM_EN` only: one checksum byte.
- FSM states: LEN_HI → LEN_LO → DATA_HI ⇄ DATA_LO → (CHK) → DONE; any state → ERROR on a fault.
- LEN_LO accept with N == 0 or N > 2^ADDR_W → ERROR. No memory write occurs.
- DATA_HI accept: latch the high byte. DATA_LO accept: register a write of {hi, lo} at address `word_count[ADDR_W-1:0]`, then increment `word_count`.
- After the Nth DATA_LO accept → CHK if the checksum is enabled, else DONE.
- DONE and ERROR are terminal. Only `reset` exits them. `in_ready` is 0 in both.
- `cpu_reset` = 1 in every state except DONE.
- Reset values: `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_reset`=1, `done`=0, `error`=0, `word_count`=0, FSM=LEN_HI.
- Reset mid-load:
  - All state returns to reset values.
  - Words already written stay in memory, but the loader does not track them.
  - `cpu_reset` remains or returns to 1.
- Arithmetic:
  - The N comparison uses the full 16 bits.
  - `word_count` never exceeds 2^ADDR_W.
  - The address is `word_count` truncated to ADDR_W bits; it never wraps, because of the N check.

## Timing
- `in_ready` is registered. It rises on the first rising edge with `reset`=1, and stays 1 while in LEN_HI..CHK, including across idle gaps.
- Throughput: one byte per cycle sustained, so one word every 2 cycles.
- Write latency: `imem_we`/`imem_addr`/`imem_wdata` are valid for exactly one cycle, the cycle after the DATA_LO accept edge. `word_count` updates on the same edge.
- `done` rises and `cpu_reset` falls on the edge after the final accept (last DATA_LO, or CHK). Without the checksum this is the same cycle as the last `imem_we`.
- `error` rises on the edge after the faulting accept. `in_ready` drops on that same edge.
- No byte is accepted on the edge that enters DONE or ERROR.

## Configuration
- `MIPS16_BOOT_CHECKSUM_EN` defined:
  - CHK state is present. The loader keeps a running XOR of every accepted byte, length bytes included.
  - The CHK byte must equal that XOR. A match → DONE; a mismatch → ERROR.
  - Words already written remain written and `word_count` is kept.
- Undefined:
  - No CHK state and no XOR register. DONE is entered directly after the Nth word.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `in_valid`=1 → `cpu_reset`=1, `in_ready`=0, `imem_we`=0, `done`=0, `error`=0, `word_count`=0; no byte consumed.
- Load 00 02 12 34 AB CD (append 42 if checksum enabled), one byte per cycle → `imem_we` pulses at addr 0 with 0x1234, then at addr 1 with 0xABCD. Then `done`=1, `cpu_reset`=0, `word_count`=2, `in_ready`=0.
- Same image with `in_valid` toggled every other cycle and 5-cycle gaps → identical writes and final state; no byte duplicated or skipped.
- Length 00 00, and separately 01 01 at ADDR_W=8 → `error`=1 the cycle after LEN_LO, no `imem_we`, `cpu_reset`=1, `in_ready`=0.
- Checksum enabled, image 00 02 12 34 AB CD 43 → both writes occur, `word_count`=2, then `error`=1, `done`=0, `cpu_reset`=1.
- Reset after the first word (00 02 12 34) → all outputs at reset values. A subsequent full load of 00 01 BE EF (checksum 50 if enabled) → write addr 0 with 0xBEEF, then `done`=1, `word_count`=1.

Source files
------------

// File: rtl/mips16_boot_loader.sv
// Byte-stream boot loader: assembles big-endian 16-bit words into the mips instruction memory
// and holds the core in reset until the image is complete. Optional MIPS16_BOOT_CHECKSUM_EN adds a trailing XOR byte.
module mips16_boot_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

`ifdef MIPS16_BOOT_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK, S_DONE, S_ERROR
   } state_t;
`else
   typedef enum logic [2:0] {
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_DONE, S_ERROR
   } state_t;
`endif

   localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

   state_t      state_reg;
   logic [7:0]  len_hi_reg;
   logic [15:0] len_reg;
   logic [7:0]  hi_reg;
`ifdef MIPS16_BOOT_CHECKSUM_EN
   logic [7:0]  chk_reg;
`endif

   logic        accept;
   logic [15:0] len_next;
   logic [16:0] count_plus_one;
   logic        last_word;

   assign accept         = in_valid & in_ready;
   assign len_next       = {len_hi_reg, in_data};
   assign count_plus_one = 17'(word_count) + 17'd1;
   assign last_word      = (count_plus_one == {1'b0, len_reg});

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg  <= S_LEN_HI;
         in_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_reset  <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
         word_count <= '0;
         len_hi_reg <= '0;
         len_reg    <= '0;
         hi_reg     <= '0;
`ifdef MIPS16_BOOT_CHECKSUM_EN
         chk_reg    <= '0;
`endif
      end else begin
         imem_we <= 1'b0;
`ifdef MIPS16_BOOT_CHECKSUM_EN
         // The checksum byte itself is excluded from the running XOR.
         if (accept && state_reg != S_CHK)
            chk_reg <= chk_reg ^ in_data;
`endif
         case (state_reg)
            S_LEN_HI: begin
               in_ready <= 1'b1;
               if (accept) begin
                  len_hi_reg <= in_data;
                  state_reg  <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (accept) begin
                  len_reg <= len_next;
                  if (len_next == 16'd0 || {1'b0, len_next} > CAPACITY) begin
                     state_reg <= S_ERROR;
                     in_ready  <= 1'b0;
                     error     <= 1'b1;
                  end else begin
                     state_reg <= S_DATA_HI;
                  end
               end
            end
            S_DATA_HI: begin
               if (accept) begin
                  hi_reg    <= in_data;
                  state_reg <= S_DATA_LO;
               end
            end
            S_DATA_LO: begin
               if (accept) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= word_count[ADDR_W-1:0];
                  imem_wdata <= {hi_reg, in_data};
                  word_count <= word_count + 1'b1;
                  if (last_word) begin
`ifdef MIPS16_BOOT_CHECKSUM_EN
                     state_reg <= S_CHK;
`else
                     state_reg <= S_DONE;
                     in_ready  <= 1'b0;
                     done      <= 1'b1;
                     cpu_reset <= 1'b0;
`endif
                  end else begin
                     state_reg <= S_DATA_HI;
                  end
               end
            end
`ifdef MIPS16_BOOT_CHECKSUM_EN
            S_CHK: begin
               if (accept) begin
                  in_ready <= 1'b0;
                  if (in_data == chk_reg) begin
                     state_reg <= S_DONE;
                     done      <= 1'b1;
                     cpu_reset <= 1'b0;
                  end else begin
                     state_reg <= S_ERROR;
                     error     <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips16_boot_loader.sv
// Self-checking bench for mips16_boot_loader: table vectors, hand-written timing sequences
// and randomized images checked against a stream-level reference model.
module tb_mips16_boot_loader;

   localparam int ADDR_W = 8;
   localparam int CAP    = 1 << ADDR_W;
`ifdef MIPS16_BOOT_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   typedef logic [7:0] byte_t;
   typedef byte_t      bq_t[$];

   typedef struct {
      logic [63:0] bytes;
      int          nb;
      int          bad_chk;
      int          gap;
      int          exp_done;
      int          exp_err;
      int          exp_wc;
   } vec_t;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = '0;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_wdata;
   logic              cpu_reset;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   word_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [ADDR_W-1:0] got_addr[$];
   logic [15:0]       got_data[$];
   logic [ADDR_W-1:0] exp_addr[$];
   logic [15:0]       exp_data[$];
   int m_done, m_err, m_wc, m_consumed;

   mips16_boot_loader #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done),
      .error(error), .word_count(word_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Write monitor; the core must be held in reset exactly when not done.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         got_addr.push_back(imem_addr);
         got_data.push_back(imem_wdata);
      end
      check("cpu_reset_vs_done", {31'd0, cpu_reset}, {31'd0, ~done});
   end

   // Reference model: derives writes and final status directly from the image bytes.
   task automatic model(input bq_t q);
      int    n;
      byte_t x;
      exp_addr.delete();
      exp_data.delete();
      n = {q[0], q[1]};
      if (n == 0 || n > CAP) begin
         m_done = 0; m_err = 1; m_wc = 0; m_consumed = 2;
         return;
      end
      for (int i = 0; i < n; i++) begin
         exp_addr.push_back(i[ADDR_W-1:0]);
         exp_data.push_back({q[2+2*i], q[3+2*i]});
      end
      m_wc = n;
      m_consumed = 2 + 2 * n;
      m_done = 1; m_err = 0;
      if (CHK_EN) begin
         x = 8'h00;
         for (int j = 0; j < 2 + 2 * n; j++) x = x ^ q[j];
         m_consumed++;
         if (q[2+2*n] != x) begin
            m_done = 0; m_err = 1;
         end
      end
   endtask

   function automatic byte_t xor_of(input bq_t q);
      byte_t x = 8'h00;
      foreach (q[i]) x = x ^ q[i];
      return x;
   endfunction

   task automatic do_reset(input bit chk);
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b1;
      in_data = 8'($urandom);
      repeat (3) @(negedge clk);
      if (chk) begin
         check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
         check("rst_in_ready", {31'd0, in_ready}, 32'd0);
         check("rst_imem_we", {31'd0, imem_we}, 32'd0);
         check("rst_imem_addr", 32'(imem_addr), 32'd0);
         check("rst_imem_wdata", 32'(imem_wdata), 32'd0);
         check("rst_done", {31'd0, done}, 32'd0);
         check("rst_error", {31'd0, error}, 32'd0);
         check("rst_word_count", 32'(word_count), 32'd0);
      end
      reset = 1'b1;
      in_valid = 1'b0;
      got_addr.delete();
      got_data.delete();
      @(negedge clk);
      if (chk) check("in_ready_after_release", {31'd0, in_ready}, 32'd1);
   endtask

   // Called at a falling edge; returns at the falling edge right after the accepting edge.
   task automatic send_byte(input byte_t b, output bit ok);
      int cnt = 0;
      ok = 1'b1;
      in_valid = 1'b1;
      in_data = b;
      while (in_ready !== 1'b1 && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 40) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
         ok = 1'b0;
         in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data = 8'($urandom);
   endtask

   task automatic run_stream(input string tag, input bq_t q, input int gap,
                             input int e_done, input int e_err, input int e_wc);
      bit ok;
      int g;
      model(q);
      do_reset(1'b0);
      for (int i = 0; i < m_consumed; i++) begin
         send_byte(q[i], ok);
         if (!ok) break;
         if (i == m_consumed - 1) begin
            check({tag, "_edge_done"}, {31'd0, done}, 32'(e_done));
            check({tag, "_edge_error"}, {31'd0, error}, 32'(e_err));
         end else begin
            g = (gap == 1) ? ((i == 3) ? 5 : 1) : (gap == 2) ? $urandom_range(0, 3) : 0;
            repeat (g) @(negedge clk);
         end
      end
      // Keep offering bytes: a terminal loader must not take any of them.
      in_valid = 1'b1;
      repeat (3) begin
         in_data = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check({tag, "_nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
      for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
         check($sformatf("%s_addr[%0d]", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
         check($sformatf("%s_data[%0d]", tag, i), 32'(got_data[i]), 32'(exp_data[i]));
      end
      check({tag, "_done"}, {31'd0, done}, 32'(e_done));
      check({tag, "_error"}, {31'd0, error}, 32'(e_err));
      check({tag, "_word_count"}, 32'(word_count), 32'(e_wc));
      check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
      $display("stream %s: %0d bytes, %0d writes, done=%0b error=%0b wc=%0d",
               tag, m_consumed, got_addr.size(), done, error, word_count);
   endtask

   vec_t vecs[6];
   bq_t  q;
   bit   ok;

   initial begin
      vecs[0] = '{64'h0002_1234_ABCD_0000, 6, 0, 0, 1, 0, 2};
      vecs[1] = '{64'h0002_1234_ABCD_0000, 6, 0, 1, 1, 0, 2};
      vecs[2] = '{64'h0000_0000_0000_0000, 2, 0, 0, 0, 1, 0};
      vecs[3] = '{64'h0101_0000_0000_0000, 2, 0, 0, 0, 1, 0};
      vecs[4] = '{64'h0001_BEEF_0000_0000, 4, 0, 2, 1, 0, 1};
      vecs[5] = '{64'h0002_1234_ABCD_0000, 6, 1, 0, CHK_EN ? 0 : 1, CHK_EN ? 1 : 0, 2};

      do_reset(1'b1);

      foreach (vecs[k]) begin
         q.delete();
         for (int i = 0; i < vecs[k].nb; i++) q.push_back(vecs[k].bytes[63-8*i -: 8]);
         if (CHK_EN) q.push_back(xor_of(q) ^ (vecs[k].bad_chk != 0 ? 8'h01 : 8'h00));
         run_stream($sformatf("vec%0d", k), q, vecs[k].gap,
                    vecs[k].exp_done, vecs[k].exp_err, vecs[k].exp_wc);
      end

      // Hand-written write-latency sequence.
      do_reset(1'b0);
      q = '{8'h00, 8'h02, 8'h12, 8'h34};
      foreach (q[i]) send_byte(q[i], ok);
      check("seq_we0", {31'd0, imem_we}, 32'd1);
      check("seq_addr0", 32'(imem_addr), 32'd0);
      check("seq_data0", 32'(imem_wdata), 32'h1234);
      check("seq_wc1", 32'(word_count), 32'd1);
      send_byte(8'hAB, ok);
      check("seq_we_idle", {31'd0, imem_we}, 32'd0);
      send_byte(8'hCD, ok);
      check("seq_we1", {31'd0, imem_we}, 32'd1);
      check("seq_addr1", 32'(imem_addr), 32'd1);
      check("seq_data1", 32'(imem_wdata), 32'hABCD);
      check("seq_wc2", 32'(word_count), 32'd2);
      check("seq_done_last_word", {31'd0, done}, {31'd0, ~CHK_EN});
      check("seq_ready_last_word", {31'd0, in_ready}, {31'd0, CHK_EN});
      if (CHK_EN) begin
         send_byte(8'h42, ok);
         check("seq_done_chk", {31'd0, done}, 32'd1);
      end
      @(negedge clk);
      check("seq_we_after", {31'd0, imem_we}, 32'd0);
      $display("sequence write-latency: done=%0b wc=%0d", done, word_count);

      // Reset after the first word, then a fresh one-word image.
      do_reset(1'b0);
      q = '{8'h00, 8'h02, 8'h12, 8'h34};
      foreach (q[i]) send_byte(q[i], ok);
      reset = 1'b0;
      @(negedge clk);
      check("mid_in_ready", {31'd0, in_ready}, 32'd0);
      check("mid_imem_we", {31'd0, imem_we}, 32'd0);
      check("mid_imem_addr", 32'(imem_addr), 32'd0);
      check("mid_imem_wdata", 32'(imem_wdata), 32'd0);
      check("mid_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("mid_word_count", 32'(word_count), 32'd0);
      check("mid_error", {31'd0, error}, 32'd0);
      reset = 1'b1;
      $display("sequence mid-load reset: wc=%0d in_ready=%0b", word_count, in_ready);
      q = '{8'h00, 8'h01, 8'hBE, 8'hEF};
      if (CHK_EN) q.push_back(8'h50);
      run_stream("after_mid_reset", q, 0, 1, 0, 1);

      // Randomized images against the model.
      for (int k = 0; k < 12; k++) begin
         int n = $urandom_range(1, 6);
         q.delete();
         q.push_back(8'(n >> 8));
         q.push_back(8'(n));
         for (int i = 0; i < 2 * n; i++) q.push_back(8'($urandom));
         if (CHK_EN) q.push_back(xor_of(q) ^ ((k % 4 == 3) ? 8'($urandom_range(1, 255)) : 8'h00));
         model(q);
         run_stream($sformatf("rand%0d", k), q, 2, m_done, m_err, m_wc);
      end

      // Full-capacity image, then an oversize length.
      q.delete();
      q.push_back(8'(CAP >> 8));
      q.push_back(8'(CAP));
      for (int i = 0; i < 2 * CAP; i++) q.push_back(8'($urandom));
      if (CHK_EN) q.push_back(xor_of(q));
      run_stream("full_capacity", q, 0, 1, 0, CAP);

      q.delete();
      begin
         int n = $urandom_range(CAP + 1, 65535);
         q.push_back(8'(n >> 8));
         q.push_back(8'(n));
      end
      run_stream("oversize", q, 0, 0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
